// File: rtl/pwm_multi_channel.sv
// Purpose    : NUM_CH-channel PWM generator with shared period/prescaler, per-channel duty and enables.
// Latency    : out/period_start registered one clock after the counter state; duty write visible 2 clocks after wr_en.
// Backpressure: none; one register write accepted every cycle, writes to unmapped addresses are dropped.
//
// Ports:
//   clk, rst_n         rising-edge clock, synchronous active-low reset
//   wr_en/addr/data    register write port: 0..NUM_CH-1 duty, NUM_CH top, NUM_CH+1 prescaler
//   en_out, en_pwm     per-channel output enable / PWM enable (en_pwm=0 forces the output high)
//   out                registered channel outputs
//   period_start       one-cycle pulse after the period counter wraps to 0
//
// Optional feature: define PWM_SHADOW_EN to latch duty values into shadow
// registers at each period wrap, so duty changes only take effect on period
// boundaries. Without it, duty writes act immediately.

module pwm_multi_channel #(
    parameter int NUM_CH = 16,
    parameter int CNT_W  = 8,
    parameter int PRE_W  = 4,
    localparam int ADDR_W = $clog2(NUM_CH + 2)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [CNT_W-1:0]  wr_data,
    input  logic [NUM_CH-1:0] en_out,
    input  logic [NUM_CH-1:0] en_pwm,
    output logic [NUM_CH-1:0] out,
    output logic              period_start
);

    logic [CNT_W-1:0]  duty [NUM_CH];
    logic [CNT_W-1:0]  d    [NUM_CH];
    logic [CNT_W-1:0]  top;
    logic [PRE_W-1:0]  pre;
    logic [PRE_W-1:0]  pcnt;
    logic [CNT_W-1:0]  cnt;
    logic              tick;
    logic              wrap;
    logic [NUM_CH-1:0] pwm;

    // Register bank
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) duty[i] <= '0;
            top <= '1;
            pre <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (int'(wr_addr) == i) duty[i] <= wr_data;
            end
            if (int'(wr_addr) == NUM_CH)     top <= wr_data;
            if (int'(wr_addr) == NUM_CH + 1) pre <= PRE_W'(wr_data);
        end
    end

    // '>=' rather than '==' so that lowering pre/top below the running count
    // wraps on the next opportunity instead of running the counter all the way round.
    assign tick = (pcnt >= pre);
    assign wrap = tick && (cnt >= top);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pcnt         <= '0;
            cnt          <= '0;
            period_start <= 1'b0;
        end else begin
            pcnt         <= tick ? '0 : PRE_W'(pcnt + 1'b1);
            if (tick) cnt <= wrap ? '0 : CNT_W'(cnt + 1'b1);
            period_start <= wrap;
        end
    end

`ifdef PWM_SHADOW_EN
    logic [CNT_W-1:0] sh [NUM_CH];

    // Shadow load samples the duty value present before any same-cycle write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) sh[i] <= '0;
        end else if (wrap) begin
            for (int i = 0; i < NUM_CH; i++) sh[i] <= duty[i];
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) d[i] = sh[i];
    end
`else
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) d[i] = duty[i];
    end
`endif

    // All-ones duty is pinned high so a full-scale setting never dips low at cnt == top.
    always_comb begin
        pwm = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            pwm[i] = (cnt < d[i]) || (d[i] == '1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) out <= '0;
        else        out <= en_out & (~en_pwm | pwm);
    end

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Purpose    : directed self-checking bench for pwm_multi_channel (default parameters).
// Latency    : outputs sampled 1 time unit after each rising edge.
// Backpressure: n/a.

module tb_pwm_multi_channel;

    localparam int NUM_CH = 16;
    localparam int CNT_W  = 8;
    localparam int PRE_W  = 4;
    localparam int ADDR_W = 5;
    localparam logic [ADDR_W-1:0] A_TOP = 5'd16;
    localparam logic [ADDR_W-1:0] A_PRE = 5'd17;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [CNT_W-1:0]  wr_data;
    logic [NUM_CH-1:0] en_out;
    logic [NUM_CH-1:0] en_pwm;
    logic [NUM_CH-1:0] out;
    logic              period_start;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    pwm_multi_channel #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRE_W(PRE_W)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .en_out(en_out), .en_pwm(en_pwm), .out(out), .period_start(period_start)
    );

    // Called just after an edge; the write lands on the following edge.
    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [CNT_W-1:0] v);
        wr_en = 1'b1; wr_addr = a; wr_data = v;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    // Waits for the next period_start pulse, returning the number of edges taken.
    task automatic sync_ps(output int n);
        n = -1;
        for (int k = 1; k <= 2000; k++) begin
            @(posedge clk); #1;
            if (period_start) begin
                n = k;
                break;
            end
        end
        checks++;
        if (n < 0) $display("FAIL sync_ps: got timeout, expected a period_start pulse");
        else passed++;
    endtask

    task automatic measure(input int ch, input int n, output int hi, output int ps);
        hi = 0; ps = 0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            if (out[ch]) hi++;
            if (period_start) ps++;
        end
    endtask

    task automatic test_reset;
        int first;
        int n;
        bit bad;
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        en_out = '1; en_pwm = '1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (out !== 16'h0) $display("FAIL reset_out: got %h expected 0000", out); else passed++;
        checks++; if (period_start !== 1'b0) $display("FAIL reset_ps: got %b expected 0", period_start); else passed++;
        rst_n = 1'b1;
        first = -1; bad = 1'b0;
        for (int k = 1; k <= 300; k++) begin
            @(posedge clk); #1;
            if (out !== 16'h0) bad = 1'b1;
            if (period_start) begin
                first = k;
                break;
            end
        end
        // Pulse is registered on the 256th edge after release, i.e. during the 257th clock period.
        checks++; if (first != 256) $display("FAIL reset_first_ps: got %0d expected 256", first); else passed++;
        checks++; if (bad) $display("FAIL reset_out_low: got nonzero out, expected 0000"); else passed++;
        sync_ps(n);
        checks++; if (n != 256) $display("FAIL reset_period: got %0d expected 256", n); else passed++;
    endtask

    task automatic test_basic_duty;
        int n, hi, ps;
        do_write(5'd3, 8'h40);
        sync_ps(n); sync_ps(n);
        measure(3, 256, hi, ps);
        checks++; if (hi != 64) $display("FAIL duty40_high: got %0d expected 64", hi); else passed++;
        checks++; if (ps != 1) $display("FAIL duty40_ps: got %0d expected 1", ps); else passed++;
        // Move into the region cnt >= 0x40 where out[3] is low.
        repeat (100) @(posedge clk);
        #1;
        do_write(5'd3, 8'hFF);
`ifndef PWM_SHADOW_EN
        checks++; if (out[3] !== 1'b0) $display("FAIL duty_lat_1: got %b expected 0", out[3]); else passed++;
        @(posedge clk); #1;
        checks++; if (out[3] !== 1'b1) $display("FAIL duty_lat_2: got %b expected 1", out[3]); else passed++;
`endif
        sync_ps(n); sync_ps(n);
        measure(3, 256, hi, ps);
        checks++; if (hi != 256) $display("FAIL dutyFF_high: got %0d expected 256", hi); else passed++;
        do_write(5'd3, 8'h00);
        sync_ps(n); sync_ps(n);
        measure(3, 256, hi, ps);
        checks++; if (hi != 0) $display("FAIL duty00_high: got %0d expected 0", hi); else passed++;
    endtask

    task automatic test_prescale;
        int n, hi, ps;
        do_write(A_TOP, 8'd9);
        do_write(A_PRE, 8'd3);
        do_write(5'd0, 8'd5);
        sync_ps(n); sync_ps(n);
        measure(0, 40, hi, ps);
        checks++; if (hi != 20) $display("FAIL pre_high: got %0d expected 20", hi); else passed++;
        checks++; if (ps != 1) $display("FAIL pre_ps_count: got %0d expected 1", ps); else passed++;
        sync_ps(n);
        checks++; if (n != 40) $display("FAIL pre_period: got %0d expected 40", n); else passed++;
    endtask

    task automatic test_enables;
        // duty[7] is 0, so the raw PWM level is low throughout.
        en_pwm[7] = 1'b0;
        checks++; if (out[7] !== 1'b0) $display("FAIL en_before: got %b expected 0", out[7]); else passed++;
        @(posedge clk); #1;
        checks++; if (out[7] !== 1'b1) $display("FAIL en_pwm_off: got %b expected 1", out[7]); else passed++;
        en_out[7] = 1'b0;
        @(posedge clk); #1;
        checks++; if (out[7] !== 1'b0) $display("FAIL en_out_off: got %b expected 0", out[7]); else passed++;
        en_out[7] = 1'b1; en_pwm[7] = 1'b1;
    endtask

    task automatic test_shadow;
        int n, hi, ps, exp_hi;
        bit mid, last_ps, exp_mid;
        do_write(A_TOP, 8'hFF);
        do_write(A_PRE, 8'h00);
        do_write(5'd1, 8'h20);
        sync_ps(n); sync_ps(n);
        // Edge i after the wrap leaves cnt = i; the write lands on edge 17 (cnt 0x10 -> 0x11).
        hi = 0; mid = 1'b0; last_ps = 1'b0;
        for (int i = 1; i <= 256; i++) begin
            @(posedge clk); #1;
            if (out[1]) hi++;
            if (i == 40) mid = out[1];
            if (i == 256) last_ps = period_start;
            if (i == 16) begin wr_en = 1'b1; wr_addr = 5'd1; wr_data = 8'hC0; end
            if (i == 17) wr_en = 1'b0;
        end
`ifdef PWM_SHADOW_EN
        exp_hi = 32; exp_mid = 1'b0;
`else
        exp_hi = 192; exp_mid = 1'b1;
`endif
        checks++; if (hi != exp_hi) $display("FAIL shadow_cur_high: got %0d expected %0d", hi, exp_hi); else passed++;
        checks++; if (mid !== exp_mid) $display("FAIL shadow_mid: got %b expected %b", mid, exp_mid); else passed++;
        checks++; if (last_ps !== 1'b1) $display("FAIL shadow_wrap_ps: got %b expected 1", last_ps); else passed++;
        measure(1, 256, hi, ps);
        checks++; if (hi != 192) $display("FAIL shadow_next_high: got %0d expected 192", hi); else passed++;
    endtask

    task automatic test_boundaries;
        int n, first;
        bit bad;
        sync_ps(n);
        repeat (128) @(posedge clk);
        #1;
        // cnt = 0x80; the write edge still compares against the old top.
        do_write(A_TOP, 8'h20);
        checks++; if (period_start !== 1'b0) $display("FAIL top_low_wr_edge: got %b expected 0", period_start); else passed++;
        @(posedge clk); #1;
        checks++; if (period_start !== 1'b1) $display("FAIL top_low_wrap: got %b expected 1", period_start); else passed++;
        sync_ps(n);
        checks++; if (n != 33) $display("FAIL top_low_period: got %0d expected 33", n); else passed++;

        do_write(A_TOP, 8'hFF);
        en_pwm[7] = 1'b0;
        sync_ps(n);
        repeat (50) @(posedge clk);
        #1;
        checks++; if (out[7] !== 1'b1) $display("FAIL pre_rst_out7: got %b expected 1", out[7]); else passed++;
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++; if (out !== 16'h0) $display("FAIL midrst_out: got %h expected 0000", out); else passed++;
        checks++; if (period_start !== 1'b0) $display("FAIL midrst_ps: got %b expected 0", period_start); else passed++;
        rst_n = 1'b1; en_pwm = '1;
        first = -1; bad = 1'b0;
        for (int k = 1; k <= 300; k++) begin
            @(posedge clk); #1;
            if (out !== 16'h0) bad = 1'b1;
            if (period_start) begin
                first = k;
                break;
            end
        end
        checks++; if (first != 256) $display("FAIL midrst_first_ps: got %0d expected 256", first); else passed++;
        checks++; if (bad) $display("FAIL midrst_duty_cleared: got nonzero out, expected 0000"); else passed++;
    endtask

    initial begin
        test_reset();
        test_basic_duty();
        test_prescale();
        test_enables();
        test_shadow();
        test_boundaries();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/pwm_multi_channel.md
# pwm_multi_channel

Parametrised multi-channel PWM generator, the successor to the fixed 16-output, single-duty `pwm_peripheral` in the onboarding top. It provides:
- per-channel duty cycles;
- a programmable period and clock prescaler;
- per-channel output and PWM enables;
- a period-start strobe.

It sits between the SPI register bank, which drives its write port and enable vectors, and the `uo_out`/`uio_out` pins.

## Interface
- `NUM_CH`, 16, number of PWM channels (1–32)
- `CNT_W`, 8, duty/period counter width in bits (4–16)
- `PRE_W`, 4, prescaler register width in bits
- localparam `ADDR_W` = `$clog2(NUM_CH+2)`
- `clk`  in  1  single system clock; all logic on rising edge
- `rst_n`  in  1  reset; synchronous, active-low
- `wr_en`  in  1  register write strobe, one write per cycle
- `wr_addr`  in  `ADDR_W`  write address
- `wr_data`  in  `CNT_W`  write data; for the prescaler, only the low `PRE_W` bits are used
- `en_out`  in  `NUM_CH`  per-channel output enable
- `en_pwm`  in  `NUM_CH`  per-channel PWM enable
- `out`  out  `NUM_CH`  registered channel outputs
- `period_start`  out  1  one-cycle pulse when the period counter wraps to 0

## Operation
- **Address map:**
  - `0..NUM_CH-1`: `duty[i]`
  - `NUM_CH`: `top` (period is `top+1` ticks)
  - `NUM_CH+1`: `pre` (tick every `pre+1` clocks)
  - Other addresses are ignored.
- **Reset values:** all `duty` = 0, `top` = all-ones, `pre` = 0, prescale counter = 0, period counter `cnt` = 0, `out` = 0, `period_start` = 0.
- **Prescaler:** `pcnt` increments each clock. When `pcnt >= pre`, `pcnt` returns to 0 and `tick` is asserted for that cycle.
- **Period counter:** on `tick`, if `cnt >= top` then `cnt` goes to 0 and `period_start` is set next cycle; otherwise `cnt` increments.
  - The `>=` comparison makes lowering `top` below the current `cnt` safe: the counter wraps on the next tick.
- **Raw PWM level:** `pwm[i]` = (`cnt < d[i]`) OR (`d[i]` == all-ones), where `d` is the effective duty (see Configuration).
  - `d` = 0 gives constant low.
  - `d` = all-ones gives constant high.
  - `d > top` (and not all-ones) gives constant high.
- **Output select:** `out[i]` = `en_out[i]` ? (`en_pwm[i]` ? `pwm[i]` : 1) : 0.
- **Write priority:** a write and a period wrap in the same cycle take effect together. The shadow load samples the pre-write value; the new value lands at the next wrap.
- **Mid-operation reset:** `rst_n` low for one rising edge returns every register and output to its reset value on that edge. No partial state survives.

## Timing
- `out` and `period_start` are registered: one clock after the `cnt`/enable state that produces them.
- An enable change is visible on `out` the next clock.
- A write to `duty` with `PWM_SHADOW_EN` undefined is visible on `out` 2 clocks after the `wr_en` edge: 1 cycle for the register write, 1 for the output register.
- With `top` = T and `pre` = P, the output period is (T+1)·(P+1) clocks. High time is `d`·(P+1) clocks for 0 < `d` ≤ T.
- `period_start` is high exactly one clock per period, including when `pre` = 0 and `top` = 0 (then it is high every cycle).

## Configuration
- Macro: `PWM_SHADOW_EN`.
- **Defined:** each channel has a shadow register `sh[i]`, loaded from `duty[i]` when `cnt` wraps to 0 and also cleared to 0 at reset. `d` = `sh[i]`, so duty changes apply only at period boundaries (glitch-free).
- **Undefined:** no shadow registers. `d` = `duty[i]` directly, so a change takes effect mid-period.

## Test plan
- **Reset:** reset, `en_out` = `en_pwm` = all-ones, no writes → `out` = 0 on all channels, `period_start` every 256 clocks, first pulse 257 clocks after reset release.
- **Basic duty:** `duty[3]` = 0x40, `top` = 0xFF, `pre` = 0 → `out[3]` high 64 of 256 clocks; `duty` 0xFF → constant high; `duty` 0 → constant low.
- **Prescale and short period:** `pre` = 3, `top` = 9, `duty[0]` = 5 → period 40 clocks, high 20; `period_start` every 40 clocks.
- **Enables:** `en_out[7]` = 0 → `out[7]` = 0. `en_out[7]` = 1 with `en_pwm[7]` = 0 → `out[7]` = 1 the next clock regardless of duty.
- **Shadow update:** with `PWM_SHADOW_EN`, `duty[1]` changed 0x20→0xC0 at `cnt` = 0x10 → current period keeps 32 high clocks, the next has 192. Without the macro → `out[1]` stays high from the change until `cnt` = 0xC0.
- **Boundaries:** `top` written from 0xFF to 0x20 while `cnt` = 0x80 → wrap on the next tick, `period_start` pulse. Reset asserted mid-period → all outputs 0 and counters 0 on that edge.
